// File: rtl/pipeline_sched.sv
// pipeline_sched: hazard and stall control for a five-stage in-order pipeline.
//
// A per-register scoreboard tracks writes still in flight. No forwarding is
// provided, so a decode-stage instruction that reads an in-flight register
// waits in ID while bubbles go into EX.
//
// Each cycle falls into exactly one case, in priority order:
//   FREEZE   - memory is busy. Everything up to EX/MEM holds. WB gets a bubble.
//   REDIRECT - EX resolved a misprediction. IF/ID and ID/EX are flushed.
//   STALL    - a RAW hazard in decode. A bubble goes into EX.
//   ADVANCE  - normal flow. A valid decode instruction issues.
// Issuing HALT moves the FSM to DRAIN. DRAIN waits until the scoreboard is
// empty and memory is idle, then enters HALTED. Only reset leaves HALTED.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   id_valid              decode stage holds a valid instruction
//   id_rs_a/_b, *_use     source registers and whether each one is read
//   id_rd, id_rd_write    destination register and write flag
//   id_is_halt            decode instruction is HALT
//   ex_mispredict         EX jump misprediction (meaningful only if !mem_busy)
//   mem_busy              MEM needs another cycle
//   en_*                  stage register enables
//   flush_*               load a bubble into the stage register
//   issue                 decode instruction advances to EX this cycle
//   halted                registered: machine halted and drained
//   stall_cnt             registered: hazard-stall cycles, saturating

module pipeline_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [2:0]  id_rs_a,
    input  logic [2:0]  id_rs_b,
    input  logic        id_rs_a_use,
    input  logic        id_rs_b_use,
    input  logic [2:0]  id_rd,
    input  logic        id_rd_write,
    input  logic        id_is_halt,
    input  logic        ex_mispredict,
    input  logic        mem_busy,
    output logic        en_pc,
    output logic        en_ifid,
    output logic        en_idex,
    output logic        en_exmem,
    output logic        en_memwb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        flush_memwb,
    output logic        issue,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t          state_q, state_nxt;
    logic [7:0][1:0] cnt_q, cnt_nxt;
    logic [15:0]     stall_cnt_q;
    logic            halted_q;
    logic            hazard;
    logic            all_clear;
    logic            cnt_dec;
    logic            cnt_set;
    logic            stall_inc;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hazard    = id_valid & ((id_rs_a_use & (cnt_q[id_rs_a] != 2'd0)) |
                                   (id_rs_b_use & (cnt_q[id_rs_b] != 2'd0)));
    assign all_clear = (cnt_q == '0);

    // Cycle classification, outputs and next state
    always_comb begin
        en_pc       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        issue       = 1'b0;
        cnt_dec     = 1'b1;
        cnt_set     = 1'b0;
        stall_inc   = 1'b0;
        state_nxt   = state_q;

        if (!reset) begin
            // During reset the pipeline sees plain ADVANCE control.
            issue   = id_valid;
            cnt_dec = 1'b0;
        end else begin
            case (state_q)
                RUN, DRAIN: begin
                    if (mem_busy) begin
                        en_pc       = 1'b0;
                        en_ifid     = 1'b0;
                        en_idex     = 1'b0;
                        en_exmem    = 1'b0;
                        flush_memwb = 1'b1;
                        cnt_dec     = 1'b0;
                    end else if (state_q == DRAIN) begin
                        en_pc      = 1'b0;
                        en_ifid    = 1'b0;
                        flush_idex = 1'b1;
                        if (all_clear)
                            state_nxt = HALTED;
                    end else if (ex_mispredict) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (hazard) begin
                        en_pc      = 1'b0;
                        en_ifid    = 1'b0;
                        flush_idex = 1'b1;
                        stall_inc  = 1'b1;
                    end else begin
                        issue   = id_valid;
                        cnt_set = id_valid & id_rd_write;
                        if (id_valid && id_is_halt)
                            state_nxt = DRAIN;
                    end
                end
                default: begin
                    en_pc    = 1'b0;
                    en_ifid  = 1'b0;
                    en_idex  = 1'b0;
                    en_exmem = 1'b0;
                    en_memwb = 1'b0;
                    cnt_dec  = 1'b0;
                end
            endcase
        end
    end

    // Scoreboard update. A new write overrides that entry's decrement.
    // The entry reads 3, 2 and 1 on the cycles after the producer issues.
    always_comb begin
        cnt_nxt = cnt_q;
        for (int r = 0; r < 8; r++) begin
            if (cnt_dec && (cnt_q[r[2:0]] != 2'd0))
                cnt_nxt[r[2:0]] = cnt_q[r[2:0]] - 2'd1;
        end
        if (cnt_set)
            cnt_nxt[id_rd] = 2'd3;
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            halted_q <= (state_nxt == HALTED);
            if (stall_inc)
                stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign halted    = halted_q;

endmodule
